// File: rtl/edge_gen_if.sv
// Edge-request bus between control logic and the edge_gen level generator.
interface edge_gen_if;
  logic rise_edge_flag;
  logic fall_edge_flag;
  logic data_out;
  logic rise_ack;
  logic fall_ack;
  logic busy;
  logic drop_flag;

  // Requester side: issues edge pulses, observes the level and handshake.
  modport master (
    output rise_edge_flag,
    output fall_edge_flag,
    input  data_out,
    input  rise_ack,
    input  fall_ack,
    input  busy,
    input  drop_flag
  );

  // Generator side.
  modport slave (
    input  rise_edge_flag,
    input  fall_edge_flag,
    output data_out,
    output rise_ack,
    output fall_ack,
    output busy,
    output drop_flag
  );
endinterface

// File: rtl/edge_gen.sv
// edge_gen: rebuilds a registered, glitch-free level from rise/fall edge pulses,
// enforcing a minimum hold width and acknowledging every accepted edge.
// Optional macro EDGE_GEN_PENDING_EN adds a one-deep pending register that
// remembers one opposite request arriving while the hold timer is running.
module edge_gen #(
  parameter int unsigned MIN_WIDTH = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  edge_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    HOLD_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    HOLD_LOW  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               data_out_q, data_out_d;
  logic               rise_ack_q, rise_ack_d;
  logic               fall_ack_q, fall_ack_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;

  logic               level_high;
  logic               hold;
  logic               accept;
  logic               opp_req;
  logic               same_req;
  logic               fire;

`ifdef EDGE_GEN_PENDING_EN
  logic               pend_q, pend_d;

  // Pending opposite-direction request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end
`else
  logic               pend_q;
  assign pend_q = 1'b0;
`endif

  // Current level and whether the hold timer permits a transition now.
  assign level_high = (state_q == HOLD_HIGH) || (state_q == IDLE_HIGH);
  assign hold       = (state_q == HOLD_HIGH) || (state_q == HOLD_LOW);
  assign accept     = !hold || (cnt_q == '0);
  assign opp_req    = level_high ? (bus.fall_edge_flag && !bus.rise_edge_flag)
                                 : (bus.rise_edge_flag && !bus.fall_edge_flag);
  assign same_req   = level_high ? (bus.rise_edge_flag && !bus.fall_edge_flag)
                                 : (bus.fall_edge_flag && !bus.rise_edge_flag);

  // Next-state, hold counter, pending and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
`ifdef EDGE_GEN_PENDING_EN
    pend_d     = pend_q;
`endif
    rise_ack_d = 1'b0;
    fall_ack_d = 1'b0;
    drop_d     = 1'b0;
    fire       = 1'b0;

    if (bus.rise_edge_flag && bus.fall_edge_flag) begin
      // Conflicting request: reject both, keep state, let the timer run.
      drop_d = 1'b1;
      if (hold && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
    end else begin
      if (same_req) drop_d = 1'b1;
      if (accept) begin
        if (opp_req || pend_q) begin
          fire = 1'b1;
        end else if (hold) begin
          state_d = level_high ? IDLE_HIGH : IDLE_LOW;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        if (opp_req) begin
`ifdef EDGE_GEN_PENDING_EN
          if (pend_q) drop_d = 1'b1;
          else        pend_d = 1'b1;
`else
          drop_d = 1'b1;
`endif
        end
      end
    end

    if (fire) begin
`ifdef EDGE_GEN_PENDING_EN
      pend_d = 1'b0;
`endif
      cnt_d      = CNT_W'(MIN_WIDTH - 1);
      state_d    = level_high ? HOLD_LOW : HOLD_HIGH;
      rise_ack_d = !level_high;
      fall_ack_d = level_high;
    end

    data_out_d = (state_d == HOLD_HIGH) || (state_d == IDLE_HIGH);
    busy_d     = (state_d == HOLD_HIGH) || (state_d == HOLD_LOW);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE_LOW;
      cnt_q      <= '0;
      data_out_q <= 1'b0;
      rise_ack_q <= 1'b0;
      fall_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      rise_ack_q <= rise_ack_d;
      fall_ack_q <= fall_ack_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.rise_ack  = rise_ack_q;
  assign bus.fall_ack  = fall_ack_q;
  assign bus.busy      = busy_q;
  assign bus.drop_flag = drop_q;

endmodule

// File: tb/tb_edge_gen.sv
// Directed bench for edge_gen: vector table on a MIN_WIDTH=4 instance, plus
// hand sequences for back-to-back toggling (MIN_WIDTH=1) and async reset.
// Expected output words are {data_out, rise_ack, fall_ack, busy, drop_flag}.
module tb_edge_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  edge_gen_if if0 ();
  edge_gen_if if1 ();

  edge_gen #(.MIN_WIDTH(4), .CNT_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if0));
  edge_gen #(.MIN_WIDTH(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rise;
    logic       fall;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [4:0] out0();
    return {if0.data_out, if0.rise_ack, if0.fall_ack, if0.busy, if0.drop_flag};
  endfunction

  function automatic logic [4:0] out1();
    return {if1.data_out, if1.rise_ack, if1.fall_ack, if1.busy, if1.drop_flag};
  endfunction

  function automatic void add(input logic r, input logic f, input logic [4:0] e);
    vec_t v;
    v.rise = r;
    v.fall = f;
    v.exp  = e;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (d ra fa busy drop)", name, got, exp);
    end
  endtask

  // Drive one request on the MIN_WIDTH=4 instance and check after the edge.
  task automatic step0(input logic r, input logic f, input logic [4:0] e, input string name);
    @(negedge clk);
    if0.rise_edge_flag = r;
    if0.fall_edge_flag = f;
    @(posedge clk);
    #1;
    check(name, out0(), e);
  endtask

  // Same for the MIN_WIDTH=1 instance.
  task automatic step1(input logic r, input logic f, input logic [4:0] e, input string name);
    @(negedge clk);
    if1.rise_edge_flag = r;
    if1.fall_edge_flag = f;
    @(posedge clk);
    #1;
    check(name, out1(), e);
  endtask

  initial begin
    if0.rise_edge_flag = 1'b0;
    if0.fall_edge_flag = 1'b0;
    if1.rise_edge_flag = 1'b0;
    if1.fall_edge_flag = 1'b0;

    // Basic rise / hold / idle / redundant / conflict / fall behaviour.
    add(0, 0, 5'b00000);
    add(1, 0, 5'b11010);
    add(0, 0, 5'b10010);
    add(0, 0, 5'b10010);
    add(0, 0, 5'b10010);
    add(0, 0, 5'b10000);
    add(1, 0, 5'b10001);
    add(0, 0, 5'b10000);
    add(0, 1, 5'b00110);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00000);
    add(1, 1, 5'b00001);
    add(0, 0, 5'b00000);
    // Fall request two cycles after an accepted rise.
    add(1, 0, 5'b11010);
    add(0, 0, 5'b10010);
`ifdef EDGE_GEN_PENDING_EN
    add(0, 1, 5'b10010);
    add(0, 0, 5'b10010);
    add(0, 0, 5'b00110);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00000);
    add(0, 0, 5'b00000);
    // Second opposite request while pending is dropped; first still fires.
    add(1, 0, 5'b11010);
    add(0, 1, 5'b10010);
    add(0, 1, 5'b10011);
    add(0, 0, 5'b10010);
    add(0, 0, 5'b00110);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00000);
`else
    add(0, 1, 5'b10011);
    add(0, 0, 5'b10010);
    add(0, 0, 5'b10000);
    add(0, 1, 5'b00110);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00010);
    add(0, 0, 5'b00000);
`endif

    // Reset state while reset is held.
    #12;
    check("reset_dut4", out0(), 5'b00000);
    check("reset_dut1", out1(), 5'b00000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step0(tbl[i].rise, tbl[i].fall, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // MIN_WIDTH=1: a transition on every edge, each with its ack, no drops.
    step1(1, 0, 5'b11010, "w1_rise0");
    step1(0, 1, 5'b00110, "w1_fall0");
    step1(1, 0, 5'b11010, "w1_rise1");
    step1(0, 1, 5'b00110, "w1_fall1");
    step1(1, 0, 5'b11010, "w1_rise2");
    step1(0, 1, 5'b00110, "w1_fall2");
    step1(0, 0, 5'b00000, "w1_idle");

    // Async reset mid-HOLD_HIGH with a fall request outstanding.
    step0(1, 0, 5'b11010, "ar_rise");
`ifdef EDGE_GEN_PENDING_EN
    step0(0, 1, 5'b10010, "ar_pend_fall");
`else
    step0(0, 1, 5'b10011, "ar_drop_fall");
`endif
    #2;
    if0.rise_edge_flag = 1'b0;
    if0.fall_edge_flag = 1'b0;
    rst = 1'b1;
    #1;
    check("ar_immediate", out0(), 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    step0(1, 0, 5'b11010, "ar_fresh_rise");
    step0(0, 0, 5'b10010, "ar_hold1");
    step0(0, 0, 5'b10010, "ar_hold2");
    step0(0, 0, 5'b10010, "ar_hold3");
    step0(0, 0, 5'b10000, "ar_idle_high");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
